// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the byte-lane data memory controller: widths,
// enable levels and the controller state encoding.
package dmem_ctrl_pkg;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int LANES   = 4;
  localparam int N_PORTS = 2;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_ctrl_if.sv
// Requester and memory-side bundle for dmem_ctrl. Index 0 is the CPU
// load/store port, index 1 the loader/debug port.
interface dmem_ctrl_if;
  import dmem_ctrl_pkg::*;

  // A requester raises req[p] with we/addr/wdata/mask and holds them stable
  // until gnt[p] pulses; that pulse is the only acknowledge. Load data then
  // follows as a one-cycle rvalid[p] pulse in the next cycle.
  logic [N_PORTS-1:0]             req;
  logic [N_PORTS-1:0]             we;
  logic [N_PORTS-1:0][ADDR_W-1:0] addr;
  logic [N_PORTS-1:0][DATA_W-1:0] wdata;
  logic [N_PORTS-1:0][LANES-1:0]  mask;
  logic [N_PORTS-1:0]             gnt;
  logic [N_PORTS-1:0]             rvalid;
  logic [N_PORTS-1:0][DATA_W-1:0] rdata;

  // Memory read data is registered: valid the cycle after mem_is_load.
  logic              mem_wren;
  logic              mem_is_load;
  logic [LANES-1:0]  mem_mask;
  logic [ADDR_W-1:0] mem_r_addr;
  logic [ADDR_W-1:0] mem_w_addr;
  logic [DATA_W-1:0] mem_w_data;
  logic [DATA_W-1:0] mem_r_data;

  modport master (
    output req, we, addr, wdata, mask, mem_r_data,
    input  gnt, rvalid, rdata,
    input  mem_wren, mem_is_load, mem_mask, mem_r_addr, mem_w_addr, mem_w_data
  );

  modport slave (
    input  req, we, addr, wdata, mask, mem_r_data,
    output gnt, rvalid, rdata,
    output mem_wren, mem_is_load, mem_mask, mem_r_addr, mem_w_addr, mem_w_data
  );
endinterface

// File: rtl/dmem_ctrl_lane_pick.sv
// Picks the lowest set byte lane of a mask as a one-hot vector and returns
// the lanes still left to write.
module dmem_ctrl_lane_pick #(
  parameter int N_LANES = 4
) (
  input  logic [N_LANES-1:0] i_mask,
  output logic [N_LANES-1:0] o_lane,
  output logic [N_LANES-1:0] o_rest
);
  logic w_found;

  always_comb begin
    o_lane  = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_LANES; i++) begin
      if (i_mask[i] && !w_found) begin
        o_lane[i] = 1'b1;
        w_found   = 1'b1;
      end
    end
  end

  assign o_rest = i_mask & ~o_lane;
endmodule

// File: rtl/dmem_ctrl.sv
// Two-port round-robin controller for a data memory that writes one byte
// lane per cycle; multi-lane stores are serialised lowest lane first.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int N_LANES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_ctrl_if.slave  io_bus,
  output logic        busy,
  output state_t      o_dbg_state
);
  state_t              r_state;
  state_t              w_next;
  logic                r_rr;
  logic                r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [N_LANES-1:0]  r_mask;

  logic                w_any;
  logic                w_win;
  logic [N_LANES-1:0]  w_pick_in;
  logic [N_LANES-1:0]  w_lane;
  logic [N_LANES-1:0]  w_rest;
  logic                w_latch;
  logic                w_mask_upd;
  logic                w_gnt_any;
  logic                w_gnt_port;

  // r_rr names the port that wins when both request at once.
  always_comb begin
    w_any = |io_bus.req;
    if (io_bus.req[0] && io_bus.req[1]) w_win = r_rr;
    else                                w_win = io_bus.req[1];
  end

  assign w_pick_in = (r_state == ST_WRITE) ? r_mask : io_bus.mask[w_win];

  dmem_ctrl_lane_pick #(.N_LANES(N_LANES)) u_lane_pick (
    .i_mask (w_pick_in),
    .o_lane (w_lane),
    .o_rest (w_rest)
  );

  always_comb begin
    w_next             = r_state;
    w_latch            = DISABLE;
    w_mask_upd         = DISABLE;
    w_gnt_any          = DISABLE;
    w_gnt_port         = 1'b0;
    io_bus.gnt         = '0;
    io_bus.rvalid      = '0;
    io_bus.rdata       = '0;
    io_bus.mem_wren    = DISABLE;
    io_bus.mem_is_load = DISABLE;
    io_bus.mem_mask    = '0;
    io_bus.mem_r_addr  = '0;
    io_bus.mem_w_addr  = '0;
    io_bus.mem_w_data  = '0;
    // Nothing is issued while reset is held, even from a stale state.
    if (rst_n) begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            if (io_bus.we[w_win]) begin
              if (w_pick_in != '0) begin
                io_bus.mem_wren   = ENABLE;
                io_bus.mem_w_addr = io_bus.addr[w_win];
                io_bus.mem_w_data = io_bus.wdata[w_win];
                io_bus.mem_mask   = w_lane;
              end
              if (w_rest == '0) begin
                io_bus.gnt[w_win] = ENABLE;
                w_gnt_any         = ENABLE;
                w_gnt_port        = w_win;
              end else begin
                w_next  = ST_WRITE;
                w_latch = ENABLE;
              end
            end else begin
              io_bus.mem_is_load = ENABLE;
              io_bus.mem_r_addr  = io_bus.addr[w_win];
              io_bus.gnt[w_win]  = ENABLE;
              w_gnt_any          = ENABLE;
              w_gnt_port         = w_win;
              w_next             = ST_READ;
              w_latch            = ENABLE;
            end
          end
        end
        ST_WRITE: begin
          io_bus.mem_wren   = ENABLE;
          io_bus.mem_w_addr = r_addr;
          io_bus.mem_w_data = r_wdata;
          io_bus.mem_mask   = w_lane;
          if (w_rest == '0) begin
            io_bus.gnt[r_owner] = ENABLE;
            w_gnt_any           = ENABLE;
            w_gnt_port          = r_owner;
            w_next              = ST_IDLE;
          end else begin
            w_mask_upd = ENABLE;
          end
        end
        ST_READ: begin
          io_bus.rvalid[r_owner] = ENABLE;
          io_bus.rdata[r_owner]  = io_bus.mem_r_data;
          w_next                 = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rr    <= 1'b0;
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_next;
      if (w_gnt_any) r_rr <= ~w_gnt_port;
      if (w_latch) begin
        r_owner <= w_win;
        r_addr  <= io_bus.addr[w_win];
        r_wdata <= io_bus.wdata[w_win];
        r_mask  <= w_rest;
      end else if (w_mask_upd) begin
        r_mask <= w_rest;
      end
    end
  end

  assign busy        = rst_n && (r_state != ST_IDLE);
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: drivers push the expected memory writes,
// grants and load data; a negedge monitor pops and compares them.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  localparam logic [1:0] K_WR  = 2'd1;
  localparam logic [1:0] K_GNT = 2'd2;
  localparam logic [1:0] K_RV  = 2'd3;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   busy;
  state_t dbg_state;
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_fail = 0;

  // {cycle[15:0], kind[1:0], port, addr[4:0], mask[3:0], data[31:0]}
  logic [59:0] exp_q[$];

  logic        tb_req[2];
  logic        tb_we[2];
  logic [4:0]  tb_addr[2];
  logic [31:0] tb_wdata[2];
  logic [3:0]  tb_mask[2];

  logic [31:0] mem_arr[32];
  logic [31:0] r_rd = '0;
  logic        mem_loaded = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_ctrl_if bus();

  assign bus.req        = {tb_req[1], tb_req[0]};
  assign bus.we         = {tb_we[1], tb_we[0]};
  assign bus.addr       = {tb_addr[1], tb_addr[0]};
  assign bus.wdata      = {tb_wdata[1], tb_wdata[0]};
  assign bus.mask       = {tb_mask[1], tb_mask[0]};
  assign bus.mem_r_data = r_rd;

  dmem_ctrl #(.N_LANES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io_bus      (bus),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // Memory model: byte-lane writes, registered reads, fixed preload.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 32; i++) mem_arr[i] <= 32'h0;
      mem_arr[1]  <= 32'h1111_0001;
      mem_arr[2]  <= 32'h2222_0002;
      mem_arr[3]  <= 32'h3333_0003;
      mem_arr[4]  <= 32'h4444_0004;
      mem_loaded  <= 1'b1;
    end else begin
      if (bus.mem_wren)
        for (int l = 0; l < 4; l++)
          if (bus.mem_mask[l]) mem_arr[bus.mem_w_addr][8*l +: 8] <= bus.mem_w_data[8*l +: 8];
      if (bus.mem_is_load) r_rd <= mem_arr[bus.mem_r_addr];
    end
  end

  task automatic expect_ev(input int at, input logic [1:0] k, input logic p,
                           input logic [4:0] a, input logic [3:0] m, input logic [31:0] d);
    exp_q.push_back({at[15:0], k, p, a, m, d});
  endtask

  function automatic void check_ev(input logic [43:0] body);
    logic [59:0] act;
    logic [59:0] exp;
    act = {cyc[15:0], body};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event cyc=%0d got=%h required=none", cyc, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL event cyc=%0d got=%h required=%h", cyc, act, exp);
      end
    end
  endfunction

  function automatic void monitor_step();
    if (bus.mem_wren) begin
      check_ev({K_WR, 1'b0, bus.mem_w_addr, bus.mem_mask, bus.mem_w_data});
      n_cmp++;
      if (!$onehot(bus.mem_mask) || bus.mem_is_load) begin
        n_fail++;
        $display("FAIL wr_exclusive cyc=%0d got mask=%b is_load=%b required onehot/0",
                 cyc, bus.mem_mask, bus.mem_is_load);
      end
    end
    for (int p = 0; p < 2; p++)
      if (bus.gnt[p]) check_ev({K_GNT, p[0], 5'd0, 4'd0, 32'd0});
    for (int p = 0; p < 2; p++)
      if (bus.rvalid[p]) check_ev({K_RV, p[0], 5'd0, 4'd0, bus.rdata[p]});
    while (exp_q.size() > 0 && int'(exp_q[0][59:44]) <= cyc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL missing_event cyc=%0d got=none required=%h", cyc, exp_q[0]);
      void'(exp_q.pop_front());
    end
  endfunction

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic drive(input int p, input logic we, input logic [4:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    int n;
    tb_we[p]    = we;
    tb_addr[p]  = a;
    tb_wdata[p] = d;
    tb_mask[p]  = m;
    tb_req[p]   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.gnt[p] && n < 20);
    check_val($sformatf("gnt_wait_p%0d", p), 32'(bus.gnt[p]), 32'd1);
    @(posedge clk);
    #1;
    tb_req[p] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    for (int p = 0; p < 2; p++) begin
      tb_req[p] = 1'b0; tb_we[p] = 1'b0; tb_addr[p] = '0; tb_wdata[p] = '0; tb_mask[p] = '0;
    end
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // Reset: outputs stay quiet even with a request pending.
    repeat (3) @(posedge clk);
    #1;
    tb_req[0] = 1'b1;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check_val("rst_gnt", 32'(bus.gnt), 32'd0);
    check_val("rst_is_load", 32'(bus.mem_is_load), 32'd0);
    tb_req[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Simultaneous loads after reset: port 0 first.
    c = cyc;
    expect_ev(c,     K_GNT, 1'b0, 5'd0, 4'd0, 32'd0);
    expect_ev(c + 1, K_RV,  1'b0, 5'd0, 4'd0, 32'h1111_0001);
    expect_ev(c + 2, K_GNT, 1'b1, 5'd0, 4'd0, 32'd0);
    expect_ev(c + 3, K_RV,  1'b1, 5'd0, 4'd0, 32'h2222_0002);
    fork
      drive(0, 1'b0, 5'd1, 32'h0, 4'h0);
      drive(1, 1'b0, 5'd2, 32'h0, 4'h0);
    join
    wait_idle();

    // Full-word store serialised over four lanes, then read back.
    c = cyc;
    expect_ev(c,     K_WR,  1'b0, 5'd3, 4'b0001, 32'hAABB_CCDD);
    expect_ev(c + 1, K_WR,  1'b0, 5'd3, 4'b0010, 32'hAABB_CCDD);
    expect_ev(c + 2, K_WR,  1'b0, 5'd3, 4'b0100, 32'hAABB_CCDD);
    expect_ev(c + 3, K_WR,  1'b0, 5'd3, 4'b1000, 32'hAABB_CCDD);
    expect_ev(c + 3, K_GNT, 1'b0, 5'd0, 4'd0, 32'd0);
    drive(0, 1'b1, 5'd3, 32'hAABB_CCDD, 4'hF);
    wait_idle();
    c = cyc;
    expect_ev(c,     K_GNT, 1'b0, 5'd0, 4'd0, 32'd0);
    expect_ev(c + 1, K_RV,  1'b0, 5'd0, 4'd0, 32'hAABB_CCDD);
    drive(0, 1'b0, 5'd3, 32'h0, 4'h0);
    wait_idle();

    // Empty-mask store: grant only.
    c = cyc;
    expect_ev(c, K_GNT, 1'b1, 5'd0, 4'd0, 32'd0);
    drive(1, 1'b1, 5'd7, 32'hDEAD_BEEF, 4'h0);
    wait_idle();

    // Two-lane store on port 0 while port 1 loads.
    c = cyc;
    expect_ev(c,     K_WR,  1'b0, 5'd9, 4'b0010, 32'h1234_5678);
    expect_ev(c + 1, K_WR,  1'b0, 5'd9, 4'b1000, 32'h1234_5678);
    expect_ev(c + 1, K_GNT, 1'b0, 5'd0, 4'd0, 32'd0);
    expect_ev(c + 2, K_GNT, 1'b1, 5'd0, 4'd0, 32'd0);
    expect_ev(c + 3, K_RV,  1'b1, 5'd0, 4'd0, 32'h4444_0004);
    fork
      drive(0, 1'b1, 5'd9, 32'h1234_5678, 4'b1010);
      drive(1, 1'b0, 5'd4, 32'h0, 4'h0);
    join
    wait_idle();

    // Single-lane store completes in one cycle; merged word read back.
    c = cyc;
    expect_ev(c, K_WR,  1'b0, 5'd9, 4'b0100, 32'hFFEE_DDCC);
    expect_ev(c, K_GNT, 1'b1, 5'd0, 4'd0, 32'd0);
    drive(1, 1'b1, 5'd9, 32'hFFEE_DDCC, 4'b0100);
    wait_idle();
    c = cyc;
    expect_ev(c,     K_GNT, 1'b1, 5'd0, 4'd0, 32'd0);
    expect_ev(c + 1, K_RV,  1'b1, 5'd0, 4'd0, 32'h12EE_5600);
    drive(1, 1'b0, 5'd9, 32'h0, 4'h0);
    wait_idle();

    // Back-to-back single-lane stores from one port.
    c = cyc;
    expect_ev(c,     K_WR,  1'b0, 5'd10, 4'b0001, 32'h0000_00AA);
    expect_ev(c,     K_GNT, 1'b0, 5'd0,  4'd0,    32'd0);
    expect_ev(c + 1, K_WR,  1'b0, 5'd10, 4'b1000, 32'hBB00_0000);
    expect_ev(c + 1, K_GNT, 1'b0, 5'd0,  4'd0,    32'd0);
    drive(0, 1'b1, 5'd10, 32'h0000_00AA, 4'b0001);
    drive(0, 1'b1, 5'd10, 32'hBB00_0000, 4'b1000);
    wait_idle();
    c = cyc;
    expect_ev(c,     K_GNT, 1'b0, 5'd0, 4'd0, 32'd0);
    expect_ev(c + 1, K_RV,  1'b0, 5'd0, 4'd0, 32'hBB00_00AA);
    drive(0, 1'b0, 5'd10, 32'h0, 4'h0);
    wait_idle();

    // Reset after two lanes of a full-word store.
    c = cyc;
    expect_ev(c,     K_WR, 1'b0, 5'd11, 4'b0001, 32'h1122_3344);
    expect_ev(c + 1, K_WR, 1'b0, 5'd11, 4'b0010, 32'h1122_3344);
    tb_we[0] = 1'b1; tb_addr[0] = 5'd11; tb_wdata[0] = 32'h1122_3344; tb_mask[0] = 4'hF;
    tb_req[0] = 1'b1;
    @(posedge clk);
    #1;
    check_val("mid_write_state", 32'(dbg_state), 32'(ST_WRITE));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    tb_req[0] = 1'b0;
    #1;
    check_val("rstw_wren", 32'(bus.mem_wren), 32'd0);
    check_val("rstw_gnt", 32'(bus.gnt), 32'd0);
    check_val("rstw_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check_val("rstw_state", 32'(dbg_state), 32'(ST_IDLE));
    check_val("rstw_busy_after", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    c = cyc;
    expect_ev(c,     K_GNT, 1'b0, 5'd0, 4'd0, 32'd0);
    expect_ev(c + 1, K_RV,  1'b0, 5'd0, 4'd0, 32'h0000_3344);
    drive(0, 1'b0, 5'd11, 32'h0, 4'h0);
    wait_idle();

    repeat (3) @(negedge clk);
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
